// File: rtl/serdes_ctrl_pkg.sv
// Shared constants and state encoding for the serializer transmit scheduler.
package serdes_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_TRAIN = 2'd1,
        ST_RUN   = 2'd2
    } tx_state_t;

    localparam int unsigned SYM_WIDTH    = 9;
    localparam logic [7:0]  COM_SYM_DEF  = 8'hBC;  // K28.5
    localparam logic [7:0]  IDLE_SYM_DEF = 8'h7C;  // K28.3

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the last-grant history lives in the parent.
module rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant,
    output logic grant_vld
);

    always_comb begin
        grant_vld = valid0 | valid1;
        grant     = 1'b0;
        if (valid0 && valid1) begin
            grant = ~last_grant;
        end else if (valid1) begin
            grant = 1'b1;
        end
    end

endmodule

// File: rtl/serdes_tx_sched.sv
// Slot-timed transmit scheduler: comma training, round-robin byte feed and idle fill
// for a 9-bit serializer, with each symbol held for a whole slot.
module serdes_tx_sched
    import serdes_ctrl_pkg::*;
#(
    parameter int unsigned SYM_BITS   = SYM_WIDTH,
    parameter int unsigned TRAIN_SYMS = 4,
    parameter logic [7:0]  COM_SYM    = COM_SYM_DEF,
    parameter logic [7:0]  IDLE_SYM   = IDLE_SYM_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_en,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_k,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_k,
    output logic       req1_ready,
    output logic       ser_enb,
    output logic [7:0] ser_data,
    output logic       ser_dk,
    output logic       slot_last,
    output logic [1:0] state
);

    localparam int unsigned SLOT_W  = $clog2(SYM_BITS);
    localparam int unsigned TRAIN_W = $clog2(TRAIN_SYMS + 1);
    localparam logic [SLOT_W-1:0]  SLOT_MAX  = SLOT_W'(SYM_BITS - 1);
    localparam logic [TRAIN_W-1:0] TRAIN_MAX = TRAIN_W'(TRAIN_SYMS);

    tx_state_t          st_q, st_d;
    logic [SLOT_W-1:0]  slot_cnt_q, slot_cnt_d;
    logic [TRAIN_W-1:0] train_cnt_q, train_cnt_d;
    logic               last_grant_q, last_grant_d;
    logic               enb_q, enb_d;
    logic [7:0]         data_q, data_d;
    logic               dk_q, dk_d;
    logic               grant, grant_vld;
    logic               run_slot_end;

    rr_arb2 u_arb (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant_q),
        .grant      (grant),
        .grant_vld  (grant_vld)
    );

    assign slot_last    = (st_q != ST_OFF) && (slot_cnt_q == SLOT_MAX);
    assign run_slot_end = slot_last && (st_q == ST_RUN) && tx_en;
    assign req0_ready   = run_slot_end && grant_vld && !grant;
    assign req1_ready   = run_slot_end && grant_vld && grant;

    assign ser_enb  = enb_q;
    assign ser_data = data_q;
    assign ser_dk   = dk_q;
    assign state    = st_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q         <= ST_OFF;
            slot_cnt_q   <= '0;
            train_cnt_q  <= '0;
            last_grant_q <= 1'b1;
            enb_q        <= 1'b0;
            data_q       <= '0;
            dk_q         <= 1'b0;
        end else begin
            st_q         <= st_d;
            slot_cnt_q   <= slot_cnt_d;
            train_cnt_q  <= train_cnt_d;
            last_grant_q <= last_grant_d;
            enb_q        <= enb_d;
            data_q       <= data_d;
            dk_q         <= dk_d;
        end
    end

    always_comb begin
        st_d         = st_q;
        train_cnt_d  = train_cnt_q;
        last_grant_d = last_grant_q;
        enb_d        = enb_q;
        data_d       = data_q;
        dk_d         = dk_q;

        if (st_q == ST_OFF || slot_last) begin
            slot_cnt_d = '0;
        end else begin
            slot_cnt_d = slot_cnt_q + SLOT_W'(1);
        end

        unique case (st_q)
            ST_OFF: begin
                if (tx_en) begin
                    st_d        = ST_TRAIN;
                    enb_d       = 1'b1;
                    data_d      = COM_SYM;
                    dk_d        = 1'b1;
                    train_cnt_d = TRAIN_W'(1);
                end
            end
            ST_TRAIN, ST_RUN: begin
                // Everything below only acts at a slot end so a symbol is never cut short.
                if (slot_last) begin
                    if (!tx_en) begin
                        st_d        = ST_OFF;
                        enb_d       = 1'b0;
                        data_d      = '0;
                        dk_d        = 1'b0;
                        train_cnt_d = '0;
                    end else if (st_q == ST_TRAIN) begin
                        if (train_cnt_q == TRAIN_MAX) begin
                            st_d   = ST_RUN;
                            data_d = IDLE_SYM;
                            dk_d   = 1'b1;
                        end else begin
                            data_d      = COM_SYM;
                            dk_d        = 1'b1;
                            train_cnt_d = train_cnt_q + TRAIN_W'(1);
                        end
                    end else if (grant_vld) begin
                        data_d       = grant ? req1_data : req0_data;
                        dk_d         = grant ? req1_k : req0_k;
                        last_grant_d = grant;
                    end else begin
                        data_d = IDLE_SYM;
                        dk_d   = 1'b1;
                    end
                end
            end
            default: begin
                st_d = ST_OFF;
            end
        endcase
    end

endmodule

// File: tb/tb_serdes_tx_sched.sv
// Directed bench for serdes_tx_sched: training, single/dual requester feed, tx_en drop and reset.
module tb_serdes_tx_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_en;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_k;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_k;
    logic       req1_ready;
    logic       ser_enb;
    logic [7:0] ser_data;
    logic       ser_dk;
    logic       slot_last;
    logic [1:0] state;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    serdes_tx_sched dut (
        .clk        (clk),
        .reset      (reset),
        .tx_en      (tx_en),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_k     (req0_k),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_k     (req1_k),
        .req1_ready (req1_ready),
        .ser_enb    (ser_enb),
        .ser_data   (ser_data),
        .ser_dk     (ser_dk),
        .slot_last  (slot_last),
        .state      (state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".state"}, 32'(state), 32'd0);
        check({tag, ".enb"}, 32'(ser_enb), 32'd0);
        check({tag, ".data"}, 32'(ser_data), 32'h00);
        check({tag, ".dk"}, 32'(ser_dk), 32'd0);
        check({tag, ".slot_last"}, 32'(slot_last), 32'd0);
        check({tag, ".ready0"}, 32'(req0_ready), 32'd0);
        check({tag, ".ready1"}, 32'(req1_ready), 32'd0);
    endtask

    // Walks one 9-clock slot starting at slot_cnt=0; optional mid-slot valid drop / tx_en drop.
    task automatic run_slot(input string tag, input logic [1:0] st, input logic [7:0] d,
                            input logic dk, input logic r0, input logic r1,
                            input int drop_at, input int txoff_at);
        for (int j = 0; j < 9; j++) begin
            if (j == drop_at) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            if (j == txoff_at) tx_en = 1'b0;
            #1;
            check({tag, ".state"}, 32'(state), 32'(st));
            check({tag, ".enb"}, 32'(ser_enb), 32'd1);
            check({tag, ".data"}, 32'(ser_data), 32'(d));
            check({tag, ".dk"}, 32'(ser_dk), 32'(dk));
            check({tag, ".slot_last"}, 32'(slot_last), (j == 8) ? 32'd1 : 32'd0);
            check({tag, ".ready0"}, 32'(req0_ready), (j == 8) ? 32'(r0) : 32'd0);
            check({tag, ".ready1"}, 32'(req1_ready), (j == 8) ? 32'(r1) : 32'd0);
            tick();
        end
    endtask

    initial begin
        reset = 1'b1;
        tx_en = 1'b1;
        req0_valid = 1'b0; req0_data = 8'h11; req0_k = 1'b0;
        req1_valid = 1'b0; req1_data = 8'h22; req1_k = 1'b1;
        tick();
        tick();
        check_reset_vals("rst");

        // Release: OFF -> TRAIN on the first edge, then four COM slots and an IDLE slot.
        reset = 1'b0;
        tick();
        for (int s = 0; s < 4; s++) run_slot("train", 2'd1, 8'hBC, 1'b1, 1'b0, 1'b0, -1, -1);

        req0_valid = 1'b1;
        run_slot("run_idle", 2'd2, 8'h7C, 1'b1, 1'b1, 1'b0, -1, -1);
        run_slot("r0_only_a", 2'd2, 8'h11, 1'b0, 1'b1, 1'b0, -1, -1);
        run_slot("r0_only_b", 2'd2, 8'h11, 1'b0, 1'b1, 1'b0, -1, -1);

        // last_grant is now 0, so contention goes to req1 first.
        req1_valid = 1'b1;
        run_slot("both_a", 2'd2, 8'h11, 1'b0, 1'b0, 1'b1, -1, -1);
        run_slot("both_b", 2'd2, 8'h22, 1'b1, 1'b1, 1'b0, -1, -1);
        run_slot("both_c", 2'd2, 8'h11, 1'b0, 1'b0, 1'b1, -1, -1);
        run_slot("both_d", 2'd2, 8'h22, 1'b1, 1'b1, 1'b0, -1, -1);

        // req1 alone withdraws mid-slot: IDLE follows and last_grant must stay 0.
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        run_slot("withdraw", 2'd2, 8'h11, 1'b0, 1'b0, 1'b0, 4, -1);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        run_slot("post_wd_a", 2'd2, 8'h7C, 1'b1, 1'b0, 1'b1, -1, -1);
        run_slot("post_wd_b", 2'd2, 8'h22, 1'b1, 1'b1, 1'b0, -1, -1);

        // tx_en dropped at slot_cnt=3: symbol finishes, then OFF.
        run_slot("txoff", 2'd2, 8'h11, 1'b0, 1'b0, 1'b0, -1, 3);
        check_reset_vals("off");
        for (int j = 0; j < 3; j++) begin
            tick();
            check_reset_vals("off_hold");
        end

        tx_en = 1'b1;
        tick();
        for (int s = 0; s < 4; s++) run_slot("retrain", 2'd1, 8'hBC, 1'b1, 1'b0, 1'b0, -1, -1);
        run_slot("rerun_idle", 2'd2, 8'h7C, 1'b1, 1'b0, 1'b1, -1, -1);

        // Reset mid-slot at slot_cnt=5.
        for (int j = 0; j < 5; j++) begin
            check("pre_rst.data", 32'(ser_data), 32'h22);
            check("pre_rst.ready0", 32'(req0_ready), 32'd0);
            check("pre_rst.ready1", 32'(req1_ready), 32'd0);
            tick();
        end
        reset = 1'b1;
        tick();
        check_reset_vals("mid_rst");
        tick();
        check_reset_vals("mid_rst_hold");

        // Fresh contention after reset: last_grant=1 so req0 wins first.
        reset = 1'b0;
        tick();
        for (int s = 0; s < 4; s++) run_slot("train2", 2'd1, 8'hBC, 1'b1, 1'b0, 1'b0, -1, -1);
        run_slot("fresh_a", 2'd2, 8'h7C, 1'b1, 1'b1, 1'b0, -1, -1);
        run_slot("fresh_b", 2'd2, 8'h11, 1'b0, 1'b0, 1'b1, -1, -1);
        run_slot("fresh_c", 2'd2, 8'h22, 1'b1, 1'b1, 1'b0, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    always @(negedge clk) begin
        if (req0_ready && req1_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_overlap: got both readys high, expected at most one (t=%0t)", $time);
        end
    end

endmodule
